// File: rtl/sdc_escaped_bus_pkg.sv
// -----------------------------------------------------------------------------
// sdc_escaped_bus_pkg
// Shared constants and the controller state type for sdc_escaped_bus_unpack.
//   LANES   : number of lanes in an assembled frame
//   LANE_W  : width of one lane and of one input nibble
//   state_e : COLLECT (gathering nibbles), FULL (completed frame waiting for
//             the output register), RESYNC (dropping until end of frame)
// -----------------------------------------------------------------------------
package sdc_escaped_bus_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        RESYNC  = 2'd2
    } state_e;

endpackage

// File: rtl/sdc_escaped_bus_unpack.sv
// -----------------------------------------------------------------------------
// sdc_escaped_bus_unpack
// Gathers a stream of nibbles into frames of LANES lanes. Nibble k of a frame
// lands on lane k; the frame is complete when the last lane arrives with
// in_last set. Completed frames are presented on y0..y3 with a valid/ready
// handshake. A frame that ends early or runs past the last lane is discarded
// and flagged with a one-cycle frame_err pulse; after an overrun the input is
// drained up to the next in_last before collection restarts.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input nibble handshake
//   in_data, in_last     : nibble payload, end-of-frame marker
//   out_valid/out_ready  : assembled frame handshake
//   y0..y3               : assembled lanes 0..3 (registered)
//   frame_err            : one-cycle pulse on an early end or an overrun
// -----------------------------------------------------------------------------
module sdc_escaped_bus_unpack #(
    parameter int LANES  = sdc_escaped_bus_pkg::LANES,
    parameter int LANE_W = sdc_escaped_bus_pkg::LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] y0,
    output logic [LANE_W-1:0] y1,
    output logic [LANE_W-1:0] y2,
    output logic [LANE_W-1:0] y3,
    output logic              frame_err
);
    import sdc_escaped_bus_pkg::*;

    localparam int               CNT_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_frame_err;
    logic [LANE_W-1:0] r_slot  [LANES];
    logic [LANE_W-1:0] r_y     [LANES];
    logic [LANE_W-1:0] w_frame [LANES];
    logic              w_accept;
    logic              w_out_free;
    logic              w_last_nib;

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_last_nib = (r_count == LAST_IDX);

    // Frame as it stands in the cycle the final nibble is accepted: earlier
    // lanes come from the collect slots, the final lane straight from in_data,
    // so a completing frame reaches the output one cycle after its last nibble.
    // NOTE: every element is assigned on every evaluation, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < LANES - 1; i++) begin
            w_frame[i] = r_slot[i];
        end
        w_frame[LANES-1] = in_data;
    end

    // NOTE: the collect slots carry no reset; a slot is always rewritten in
    // the current frame before anything reads it, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == COLLECT)) begin
            r_slot[r_count] <= in_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_y[i] <= '0;
            end
        end else begin
            r_frame_err <= 1'b0;
            r_in_ready  <= 1'b1;

            // Consumption empties the output unless a transfer below refills it.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_last_nib) begin
                            r_count <= '0;
                            if (!in_last) begin
                                r_frame_err <= 1'b1;
                                r_state     <= RESYNC;
                            end else if (w_out_free) begin
                                for (int i = 0; i < LANES; i++) begin
                                    r_y[i] <= w_frame[i];
                                end
                                r_out_valid <= 1'b1;
                            end else begin
                                // Output still occupied: park the frame in the
                                // collect slots and stall the input.
                                r_state    <= FULL;
                                r_in_ready <= 1'b0;
                            end
                        end else if (in_last) begin
                            r_count     <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end

                FULL: begin
                    if (out_ready) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_y[i] <= r_slot[i];
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= COLLECT;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end

                RESYNC: begin
                    if (w_accept && in_last) begin
                        r_state <= COLLECT;
                    end
                end

                default: begin
                    r_state <= COLLECT;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign y0        = r_y[0];
    assign y1        = r_y[1];
    assign y2        = r_y[2];
    assign y3        = r_y[3];

endmodule

// File: tb/tb_sdc_escaped_bus_unpack.sv
// -----------------------------------------------------------------------------
// tb_sdc_escaped_bus_unpack
// Self-checking bench: directed frame scenarios plus randomized traffic, with
// every cycle compared against a frame-level reference model (nibble queue,
// held output frame, one pending frame, drop flag).
// -----------------------------------------------------------------------------
module tb_sdc_escaped_bus_unpack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y0, y1, y2, y3;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the DUT, compared against constants in directed tests.
    logic [15:0] obs_deliv[$];
    int          obs_err;
    int          n_steps;

    // Reference model state.
    bit       m_started;
    bit [3:0] m_q[$];
    bit       m_dropping;
    bit       m_out_valid;
    bit [3:0] m_out[4];
    bit       m_pend_valid;
    bit [3:0] m_pend[4];
    bit       m_err;

    always #5 clk = ~clk;

    sdc_escaped_bus_unpack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_started    = 1'b0;
        m_q.delete();
        m_dropping   = 1'b0;
        m_out_valid  = 1'b0;
        m_pend_valid = 1'b0;
        m_err        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_out[i]  = '0;
            m_pend[i] = '0;
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit       acc;
        bit       free;
        bit [3:0] f[4];
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc   = in_valid && m_started && !m_pend_valid;
        free  = !m_out_valid || out_ready;
        m_err = 1'b0;
        if (m_out_valid && out_ready) m_out_valid = 1'b0;
        if (m_pend_valid) begin
            if (out_ready) begin
                m_out        = m_pend;
                m_out_valid  = 1'b1;
                m_pend_valid = 1'b0;
            end
        end else if (acc) begin
            if (m_dropping) begin
                if (in_last) m_dropping = 1'b0;
            end else begin
                m_q.push_back(in_data);
                if (m_q.size() == 4) begin
                    if (!in_last) begin
                        m_err      = 1'b1;
                        m_dropping = 1'b1;
                    end else begin
                        for (int i = 0; i < 4; i++) f[i] = m_q[i];
                        if (free) begin
                            m_out       = f;
                            m_out_valid = 1'b1;
                        end else begin
                            m_pend       = f;
                            m_pend_valid = 1'b1;
                        end
                    end
                    m_q.delete();
                end else if (in_last) begin
                    m_err = 1'b1;
                    m_q.delete();
                end
            end
        end
        m_started = 1'b1;
    endtask

    task automatic compare();
        check("in_ready",  in_ready,  m_started && !m_pend_valid);
        check("out_valid", out_valid, m_out_valid);
        check("frame_err", frame_err, m_err);
        check("y0", y0, m_out[0]);
        check("y1", y1, m_out[1]);
        check("y2", y2, m_out[2]);
        check("y3", y3, m_out[3]);
        if (frame_err === 1'b1) obs_err++;
    endtask

    // One clock cycle: apply inputs, record any handshake, clock, compare.
    task automatic step(input bit v, input bit [3:0] d, input bit l, input bit ordy,
                        output bit accepted);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        accepted = v && m_started && !m_pend_valid;
        if (rst_n && out_valid && out_ready) obs_deliv.push_back({y3, y2, y1, y0});
        model_edge();
        @(posedge clk);
        #1;
        n_steps++;
        compare();
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        step(1'b0, 4'h0, 1'b0, ordy, acc);
    endtask

    task automatic send(input bit [3:0] d, input bit l, input int ordy_pct);
        bit acc;
        bit done;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            step(1'b1, d, l, ($urandom_range(0, 99) < ordy_pct), acc);
            done = acc;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input bit [15:0] nibs, input int ordy_pct);
        for (int k = 0; k < 4; k++) send(nibs[4*k +: 4], k == 3, ordy_pct);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_y", {y3, y2, y1, y0}, 0);
        check("rst_async_frame_err", frame_err, 0);
        check("rst_async_in_ready", in_ready, 0);
        idle(1'b1);
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int len;
        int r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        obs_err   = 0;
        n_steps   = 0;
        model_reset();
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_y", {y3, y2, y1, y0}, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);
        check("ready_after_reset", in_ready, 1);

        // Single frame, minimal latency.
        send_frame(16'h4321, 100);
        check("single_valid", out_valid, 1);
        check("single_y", {y3, y2, y1, y0}, 16'h4321);
        idle(1'b1);
        check("single_consumed", out_valid, 0);

        // Back-to-back frames with no bubble.
        s = n_steps;
        send_frame(16'hDCBA, 100);
        check("b2b_first_valid", out_valid, 1);
        check("b2b_first_y", {y3, y2, y1, y0}, 16'hDCBA);
        send_frame(16'h8765, 100);
        check("b2b_second_valid", out_valid, 1);
        check("b2b_second_y", {y3, y2, y1, y0}, 16'h8765);
        check("b2b_cycles", n_steps - s, 8);
        idle(1'b1);

        // Backpressure: second frame parks, input stalls, order preserved.
        obs_deliv.delete();
        send_frame(16'h4321, 0);
        send_frame(16'h8765, 0);
        check("full_in_ready", in_ready, 0);
        check("full_y_held", {y3, y2, y1, y0}, 16'h4321);
        idle(1'b0);
        check("full_stays", in_ready, 0);
        idle(1'b1);
        idle(1'b1);
        check("full_deliv_n", obs_deliv.size(), 2);
        if (obs_deliv.size() == 2) begin
            check("full_deliv_0", obs_deliv[0], 16'h4321);
            check("full_deliv_1", obs_deliv[1], 16'h8765);
        end

        // Early end, then a good frame.
        obs_deliv.delete();
        obs_err = 0;
        send(4'h9, 1'b0, 100);
        send(4'h9, 1'b1, 100);
        send_frame(16'h4321, 100);
        idle(1'b1);
        check("early_err_n", obs_err, 1);
        check("early_deliv_n", obs_deliv.size(), 1);
        if (obs_deliv.size() == 1) check("early_deliv", obs_deliv[0], 16'h4321);

        // Overrun: six nibbles, last only on the sixth.
        obs_deliv.delete();
        obs_err = 0;
        for (int k = 0; k < 6; k++) begin
            send(4'(4'hA + k), k == 5, 100);
            if (k == 3) check("overrun_err_pulse", frame_err, 1);
        end
        send_frame(16'h4321, 100);
        idle(1'b1);
        check("overrun_err_n", obs_err, 1);
        check("overrun_deliv_n", obs_deliv.size(), 1);
        if (obs_deliv.size() == 1) check("overrun_deliv", obs_deliv[0], 16'h4321);

        // Reset in the middle of a frame.
        obs_deliv.delete();
        obs_err = 0;
        send(4'h7, 1'b0, 100);
        send(4'h7, 1'b0, 100);
        do_reset();
        send_frame(16'h4321, 100);
        idle(1'b1);
        check("midrst_err_n", obs_err, 0);
        check("midrst_deliv_n", obs_deliv.size(), 1);
        if (obs_deliv.size() == 1) check("midrst_deliv", obs_deliv[0], 16'h4321);

        // Randomized traffic against the model.
        for (int fr = 0; fr < 400; fr++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      len = 4;
            else if (r < 8) len = $urandom_range(1, 3);
            else            len = $urandom_range(5, 7);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 1) == 1);
                send(4'($urandom), k == len - 1, 70);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        for (int k = 0; k < 4; k++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
